// File: rtl/ldtu_sched_pkg.sv
// Shared types and constants for the LiTe-DTU word scheduler: FSM encoding,
// idle filler word and the mode-change marker words.
package ldtu_sched_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL        = 2'd0,
    ST_DRAIN_TO_FB   = 2'd1,
    ST_FALLBACK      = 2'd2,
    ST_DRAIN_TO_NORM = 2'd3
  } sched_state_t;

  localparam logic [31:0] IDLE_WORD_DEF  = 32'hEAAAAAAA;
  localparam logic [31:0] MARKER_TO_FB   = 32'h5A5AF00B;
  localparam logic [31:0] MARKER_TO_NORM = 32'h5A5A000B;

  // Up to two words can be lost in one cycle (displaced source word plus a
  // marker hitting a full FIFO), so the increment is two bits wide.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/ldtu_sched_fifo.sv
// Output word FIFO: register array with a combinational head, wrapping
// pointers, an occupancy level and write-drop indication on overflow.
module ldtu_sched_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [31:0]   i_wr_data,
  input  logic          i_rd_en,
  output logic [31:0]   o_rd_data,
  output logic          o_empty,
  output logic [LW-1:0] o_level,
  output logic          o_wr_drop
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_do;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = i_rd_en & ~w_empty;
  // A pop frees the head slot this cycle, so a full FIFO still takes the write.
  assign w_wr_do = i_wr_en & (~w_full | w_pop);

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = w_empty;
  assign o_level   = r_level;
  assign o_wr_drop = i_wr_en & w_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (w_wr_do) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_do) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_do, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ldtu_word_scheduler.sv
// LiTe-DTU word scheduler: selects normal/fallback source, drains across mode
// switches and queues words for the serializer. Optional: LDTU_SCHED_MARKER_EN.
module ldtu_word_scheduler
  import ldtu_sched_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter int          GUARD_CYC = 4,
  parameter logic [31:0] IDLE_WORD = IDLE_WORD_DEF
) (
  input  logic                     CLK,
  input  logic                     rst_b,
  input  logic                     fallback_req,
  input  logic [31:0]              DATA_32,
  input  logic                     Load,
  input  logic [31:0]              DATA_32_FB,
  input  logic                     Load_FB,
  input  logic                     word_ready,
  output logic                     fallback,
  output logic [31:0]              word_out,
  output logic                     word_is_idle,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               ovf_cnt,
  output logic                     switching
);

  localparam int              GW         = $clog2(GUARD_CYC) + 1;
  localparam logic [GW-1:0]   GUARD_LAST = GW'(GUARD_CYC - 1);

  sched_state_t r_state;
  logic [GW-1:0] r_guard;
  logic          r_fallback;
  logic          r_switching;
  logic [7:0]    r_ovf;

  logic          w_src_normal;
  logic          w_src_wr;
  logic [31:0]   w_src_data;
  logic          w_src_lost;
  logic          w_wr_en;
  logic [31:0]   w_wr_data;
  logic          w_fifo_drop;
  logic          w_fifo_empty;
  logic [31:0]   w_fifo_head;
  logic [1:0]    w_drop_inc;

  // The old source stays selected throughout its DRAIN state.
  assign w_src_normal = (r_state == ST_NORMAL) | (r_state == ST_DRAIN_TO_FB);
  assign w_src_wr     = w_src_normal ? Load : Load_FB;
  assign w_src_data   = w_src_normal ? DATA_32 : DATA_32_FB;

`ifdef LDTU_SCHED_MARKER_EN
  logic        r_mark_pend;
  logic [31:0] r_mark_word;

  assign w_wr_en    = r_mark_pend | w_src_wr;
  assign w_wr_data  = r_mark_pend ? r_mark_word : w_src_data;
  assign w_src_lost = r_mark_pend & w_src_wr;
`else
  assign w_wr_en    = w_src_wr;
  assign w_wr_data  = w_src_data;
  assign w_src_lost = 1'b0;
`endif

  assign w_drop_inc = {1'b0, w_fifo_drop} + {1'b0, w_src_lost};

  ldtu_sched_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst_n   (rst_b),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_rd_en   (word_ready),
    .o_rd_data (w_fifo_head),
    .o_empty   (w_fifo_empty),
    .o_level   (fifo_level),
    .o_wr_drop (w_fifo_drop)
  );

  assign word_out     = w_fifo_empty ? IDLE_WORD : w_fifo_head;
  assign word_is_idle = w_fifo_empty;
  assign fallback     = r_fallback;
  assign switching    = r_switching;
  assign ovf_cnt      = r_ovf;

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= ST_NORMAL;
      r_guard     <= '0;
      r_fallback  <= 1'b0;
      r_switching <= 1'b0;
      r_ovf       <= 8'd0;
`ifdef LDTU_SCHED_MARKER_EN
      r_mark_pend <= 1'b0;
      r_mark_word <= 32'd0;
`endif
    end else begin
      r_ovf <= sat_add8(r_ovf, w_drop_inc);
`ifdef LDTU_SCHED_MARKER_EN
      r_mark_pend <= 1'b0;
`endif
      case (r_state)
        ST_NORMAL: begin
          if (fallback_req) begin
            r_state     <= ST_DRAIN_TO_FB;
            r_guard     <= '0;
            r_switching <= 1'b1;
          end
        end
        ST_DRAIN_TO_FB: begin
          if (!fallback_req) begin
            r_state     <= ST_NORMAL;
            r_guard     <= '0;
            r_switching <= 1'b0;
          end else if (r_guard == GUARD_LAST) begin
            r_state     <= ST_FALLBACK;
            r_guard     <= '0;
            r_fallback  <= 1'b1;
            r_switching <= 1'b0;
`ifdef LDTU_SCHED_MARKER_EN
            r_mark_pend <= 1'b1;
            r_mark_word <= MARKER_TO_FB;
`endif
          end else begin
            r_guard <= r_guard + 1'b1;
          end
        end
        ST_FALLBACK: begin
          if (!fallback_req) begin
            r_state     <= ST_DRAIN_TO_NORM;
            r_guard     <= '0;
            r_switching <= 1'b1;
          end
        end
        ST_DRAIN_TO_NORM: begin
          if (fallback_req) begin
            r_state     <= ST_FALLBACK;
            r_guard     <= '0;
            r_switching <= 1'b0;
          end else if (r_guard == GUARD_LAST) begin
            r_state     <= ST_NORMAL;
            r_guard     <= '0;
            r_fallback  <= 1'b0;
            r_switching <= 1'b0;
`ifdef LDTU_SCHED_MARKER_EN
            r_mark_pend <= 1'b1;
            r_mark_word <= MARKER_TO_NORM;
`endif
          end else begin
            r_guard <= r_guard + 1'b1;
          end
        end
        default: begin
          r_state <= ST_NORMAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldtu_word_scheduler.sv
// Directed self-checking bench for ldtu_word_scheduler (default parameters);
// marker expectations follow LDTU_SCHED_MARKER_EN when it is defined.
module tb_ldtu_word_scheduler;

  logic        CLK = 1'b0;
  logic        rst_b = 1'b0;
  logic        fallback_req = 1'b0;
  logic [31:0] DATA_32 = 32'd0;
  logic        Load = 1'b0;
  logic [31:0] DATA_32_FB = 32'd0;
  logic        Load_FB = 1'b0;
  logic        word_ready = 1'b0;
  logic        fallback;
  logic [31:0] word_out;
  logic        word_is_idle;
  logic [3:0]  fifo_level;
  logic [7:0]  ovf_cnt;
  logic        switching;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] IDLE = 32'hEAAAAAAA;

`ifdef LDTU_SCHED_MARKER_EN
  localparam int MK = 1;
`else
  localparam int MK = 0;
`endif

  ldtu_word_scheduler dut (
    .CLK          (CLK),
    .rst_b        (rst_b),
    .fallback_req (fallback_req),
    .DATA_32      (DATA_32),
    .Load         (Load),
    .DATA_32_FB   (DATA_32_FB),
    .Load_FB      (Load_FB),
    .word_ready   (word_ready),
    .fallback     (fallback),
    .word_out     (word_out),
    .word_is_idle (word_is_idle),
    .fifo_level   (fifo_level),
    .ovf_cnt      (ovf_cnt),
    .switching    (switching)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %0d %s observed=%h expected=%h", checks, tag, obs, exp);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_word", word_out, IDLE);
    chk("rst_idle", 32'(word_is_idle), 32'd1);
    chk("rst_fb", 32'(fallback), 32'd0);
    chk("rst_sw", 32'(switching), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    rst_b = 1'b1;
    tick();

    // Three loads, then drain in order
    Load = 1'b1; DATA_32 = 32'h11111111;
    tick();
    chk("lat1_word", word_out, 32'h11111111);
    chk("lat1_idle", 32'(word_is_idle), 32'd0);
    DATA_32 = 32'h22222222;
    tick();
    DATA_32 = 32'h33333333;
    tick();
    Load = 1'b0;
    chk("three_level", 32'(fifo_level), 32'd3);
    word_ready = 1'b1;
    chk("pop_w1", word_out, 32'h11111111);
    tick();
    chk("pop_w2", word_out, 32'h22222222);
    tick();
    chk("pop_w3", word_out, 32'h33333333);
    tick();
    chk("pop_idle_word", word_out, IDLE);
    chk("pop_idle_flag", 32'(word_is_idle), 32'd1);
    tick();
    chk("pop_empty_noeff", 32'(fifo_level), 32'd0);
    word_ready = 1'b0;

    // Overflow: 10 loads into 8 slots
    Load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      DATA_32 = 32'hA0000000 + 32'(i);
      tick();
    end
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_cnt2", 32'(ovf_cnt), 32'd2);
    chk("ovf_head", word_out, 32'hA0000000);
    DATA_32 = 32'hA00000FF;
    word_ready = 1'b1;
    tick();
    Load = 1'b0;
    chk("full_wrpop_level", 32'(fifo_level), 32'd8);
    chk("full_wrpop_ovf", 32'(ovf_cnt), 32'd2);
    chk("full_wrpop_head", word_out, 32'hA0000001);
    for (int i = 0; i < 7; i++) tick();
    chk("wrap_last_word", word_out, 32'hA00000FF);
    tick();
    word_ready = 1'b0;
    chk("drain_level", 32'(fifo_level), 32'd0);

    // Switch to fallback
    fallback_req = 1'b1;
    tick();
    chk("dfb_sw_e1", 32'(switching), 32'd1);
    chk("dfb_fb_e1", 32'(fallback), 32'd0);
    Load = 1'b1; DATA_32 = 32'hBBBB0001;
    Load_FB = 1'b1; DATA_32_FB = 32'hFB000001;
    tick();
    Load = 1'b0; Load_FB = 1'b0;
    chk("dfb_load_kept", 32'(fifo_level), 32'd1);
    chk("dfb_load_word", word_out, 32'hBBBB0001);
    tick();
    tick();
    chk("dfb_sw_e4", 32'(switching), 32'd1);
    chk("dfb_fb_e4", 32'(fallback), 32'd0);
    tick();
    chk("fb_fb_e5", 32'(fallback), 32'd1);
    chk("fb_sw_e5", 32'(switching), 32'd0);
    tick();
    chk("fb_marker_level", 32'(fifo_level), 32'(1 + MK));
    Load_FB = 1'b1; DATA_32_FB = 32'hFB000002;
    Load = 1'b1; DATA_32 = 32'hBBBB0002;
    tick();
    Load_FB = 1'b0; Load = 1'b0;
    chk("fb_load_level", 32'(fifo_level), 32'(2 + MK));
    word_ready = 1'b1;
    chk("fb_q0", word_out, 32'hBBBB0001);
    tick();
    if (MK == 1) begin
      chk("fb_marker", word_out, 32'h5A5AF00B);
      tick();
    end
    chk("fb_q_fbword", word_out, 32'hFB000002);
    tick();
    chk("fb_q_empty", word_out, IDLE);
    word_ready = 1'b0;

    // Back to normal
    fallback_req = 1'b0;
    tick();
    chk("dn_sw_e1", 32'(switching), 32'd1);
    chk("dn_fb_e1", 32'(fallback), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("dn_fb_e5", 32'(fallback), 32'd0);
    chk("dn_sw_e5", 32'(switching), 32'd0);
    tick();
    chk("dn_marker_level", 32'(fifo_level), 32'(MK));
    chk("dn_marker_word", word_out, (MK == 1) ? 32'h5A5A000B : IDLE);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;

    // Abort a switch on the 2nd DRAIN cycle
    fallback_req = 1'b1;
    tick();
    tick();
    chk("abort_sw_c2", 32'(switching), 32'd1);
    fallback_req = 1'b0;
    tick();
    chk("abort_sw_low", 32'(switching), 32'd0);
    chk("abort_fb", 32'(fallback), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_fb_later", 32'(fallback), 32'd0);
    chk("abort_no_marker", 32'(fifo_level), 32'd0);
    Load = 1'b1; DATA_32 = 32'hCCCC0001;
    tick();
    Load = 1'b0;
    chk("abort_normal_src", word_out, 32'hCCCC0001);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;

    // Reset mid-DRAIN with 5 words queued
    Load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      DATA_32 = 32'hD0000000 + 32'(i);
      tick();
    end
    Load = 1'b0;
    chk("pre_rst_level", 32'(fifo_level), 32'd5);
    fallback_req = 1'b1;
    tick();
    tick();
    chk("pre_rst_sw", 32'(switching), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_fb", 32'(fallback), 32'd0);
    chk("arst_word", word_out, IDLE);
    chk("arst_sw", 32'(switching), 32'd0);
    chk("arst_ovf", 32'(ovf_cnt), 32'd0);
    fallback_req = 1'b0;
    #1;
    rst_b = 1'b1;
    tick();
    tick();
    chk("post_rst_level", 32'(fifo_level), 32'd0);

    // Saturating overflow counter: 8 fills + 300 drops
    Load = 1'b1;
    for (int i = 0; i < 8 + 254; i++) begin
      DATA_32 = 32'(i);
      tick();
    end
    chk("sat_254", 32'(ovf_cnt), 32'd254);
    for (int i = 0; i < 46; i++) tick();
    Load = 1'b0;
    chk("sat_255", 32'(ovf_cnt), 32'd255);
    chk("sat_level", 32'(fifo_level), 32'd8);
    chk("sat_head", word_out, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
